// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings and constants for the HI/LO multiply/divide
//               unit. Holds the operation codes, the FSM state type, the
//               iteration count and the divide-by-zero LO value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_t;

  // Counter load value: steps are taken at counts 31..0, i.e. 32 steps.
  localparam logic [4:0]  ITER_LAST = 5'd31;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

  // Op[1] selects divide, Op[0] selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit_if
// Description : Request/result bundle between the datapath control and the
//               multiply/divide unit.
// Ports       : master drives Start/Op/inA/inB/WriteHi/WriteLo/WrData and
//               observes Busy/Done/DivByZero/HiOut/LoOut; slave is the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              Start;
  logic [1:0]        Op;
  logic [DATA_W-1:0] inA;
  logic [DATA_W-1:0] inB;
  logic              WriteHi;
  logic              WriteLo;
  logic [DATA_W-1:0] WrData;
  logic              Busy;
  logic              Done;
  logic              DivByZero;
  logic [DATA_W-1:0] HiOut;
  logic [DATA_W-1:0] LoOut;

  modport master (
    output Start, Op, inA, inB, WriteHi, WriteLo, WrData,
    input  Busy, Done, DivByZero, HiOut, LoOut
  );

  modport slave (
    input  Start, Op, inA, inB, WriteHi, WriteLo, WrData,
    output Busy, Done, DivByZero, HiOut, LoOut
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit_datapath.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_datapath
// Description : Magnitude registers, 64-bit accumulator and the per-cycle
//               shift-add (multiply) / restoring shift-subtract (divide) step,
//               plus the sign-corrected HI/LO result.
// Ports       : Clk, Reset       - clock, async active-high reset
//               load, step, fix  - strobes from the control FSM
//               op, a, b         - operation and raw operands (sampled on load)
//               hi_res, lo_res   - sign-corrected result for HI/LO
//               div_zero         - current operation is a divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              step,
  input  logic              fix,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res,
  output logic              div_zero
);
  localparam int W = DATA_W;

  logic [W-1:0]   mag_a, mag_b;
  logic           is_div, sign_a, sign_b;
  logic [2*W-1:0] acc;

  logic           in_sign_a, in_sign_b;
  logic [W-1:0]   abs_a, abs_b;

  assign in_sign_a = op_is_signed(op) & a[W-1];
  assign in_sign_b = op_is_signed(op) & b[W-1];
  assign abs_a     = in_sign_a ? -a : a;
  assign abs_b     = in_sign_b ? -b : b;

  // Multiply: acc = {partial, multiplier}; add multiplicand into the upper
  // half when the multiplier LSB is set, then shift right with the carry.
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, mag_a};

  // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into
  // the remainder and subtract if it fits. The shifted remainder needs W+1 bits.
  logic [W:0]   rem_sh;
  logic         fits;
  logic [W-1:0] rem_sub;
  assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
  assign fits    = rem_sh >= {1'b0, mag_b};
  assign rem_sub = rem_sh[W-1:0] - mag_b;

  logic [2*W-1:0] acc_step;
  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (fits) acc_step = {rem_sub,          acc[W-2:0], 1'b1};
      else      acc_step = {rem_sh[W-1:0],    acc[W-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[W-1:1]};
    end else begin
      acc_step = {1'b0, acc[2*W-1:1]};
    end
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, div0_hi;
  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
  // Re-negating the magnitude recovers the original dividend bit pattern.
  assign div0_hi  = sign_a ? -mag_a : mag_a;
  assign div_zero = is_div & (mag_b == '0);

  always_comb begin
    hi_res = prod_fix[2*W-1:W];
    lo_res = prod_fix[W-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_res = div0_hi;
        lo_res = DIV0_LO;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mag_a  <= '0;
      mag_b  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
    end else if (load) begin
      mag_a  <= abs_a;
      mag_b  <= abs_b;
      is_div <= op_is_div(op);
      sign_a <= in_sign_a;
      sign_b <= in_sign_b;
      acc    <= op_is_div(op) ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
    end else if (step) begin
      acc <= acc_step;
    end else if (fix) begin
      acc <= {hi_res, lo_res};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural
//               HI/LO registers and MTHI/MTLO writes. 33-cycle latency.
// Ports       : Clk, Reset - clock, async active-high reset
//               bus (slave) - Start/Op/inA/inB request, WriteHi/WriteLo/WrData
//                             moves, Busy/Done/DivByZero status, HiOut/LoOut
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  hilo_muldiv_unit_if.slave  bus
);
  state_t            state, state_nxt;
  logic [4:0]        count;
  logic              load, step, fix;
  logic [DATA_W-1:0] hi_res, lo_res;
  logic              div_zero;

  muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .op       (bus.Op),
    .a        (bus.inA),
    .b        (bus.inB),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          load      = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (count == '0) state_nxt = ST_SIGN;
      end
      ST_SIGN: begin
        fix       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      bus.Busy      <= 1'b0;
      bus.Done      <= 1'b0;
      bus.DivByZero <= 1'b0;
      bus.HiOut     <= '0;
      bus.LoOut     <= '0;
    end else begin
      state         <= state_nxt;
      bus.Busy      <= (state_nxt != ST_IDLE);
      bus.Done      <= fix;
      bus.DivByZero <= fix & div_zero;

      if (load)                    count <= ITER_LAST;
      else if (step && count != 0) count <= count - 1'b1;

      // HI/LO change only on completion or on a move in a quiet IDLE cycle;
      // a Start in the same cycle takes priority and the move is dropped.
      if (fix) begin
        bus.HiOut <= hi_res;
        bus.LoOut <= lo_res;
      end else if (state == ST_IDLE && !bus.Start) begin
        if (bus.WriteHi) bus.HiOut <= bus.WrData;
        if (bus.WriteLo) bus.LoOut <= bus.WrData;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Self-checking bench for hilo_muldiv_unit. Expected HI/LO
//               results are queued when an operation is issued and compared
//               whenever Done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  hilo_muldiv_unit_if #(.DATA_W(32)) bus ();

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // ---------------- scoreboard monitor ----------------
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (bus.Done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: hi=%h lo=%h with no expected result", bus.HiOut, bus.LoOut);
      end else begin
        e = sb.pop_front();
        if (bus.HiOut !== e.hi || bus.LoOut !== e.lo || bus.DivByZero !== e.dbz) begin
          miscompares++;
          $display("FAIL %s: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                   e.name, bus.HiOut, bus.LoOut, bus.DivByZero, e.hi, e.lo, e.dbz);
        end
      end
    end
  end

  function automatic void push_exp(input logic [31:0] hi, input logic [31:0] lo,
                                   input logic dbz, input string name);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.name = name;
    sb.push_back(e);
  endfunction

  // Reference model built on native SV arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sp;
    logic [63:0] up;
    int          sa, sbv;
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    sa  = int'(a);
    sbv = int'(b);
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sbv);
        up = 64'(sp);
        hi = up[63:32]; lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (op == 2'b11) begin
          lo = a / b; hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'd0;
        end else begin
          lo = 32'(sa / sbv); hi = 32'(sa % sbv);
        end
      end
    endcase
  endfunction

  // Drives Start for one edge (E0); returns #1 after E0.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    bus.Op = op; bus.inA = a; bus.inB = b; bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
  endtask

  // Counts edges until Done is seen (bounded); returns #1 after that edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < 100) begin
      @(posedge Clk); #1; cyc++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, output int cyc);
    logic [31:0] h, l;
    logic        z;
    model(op, a, b, h, l, z);
    push_exp(h, l, z, name);
    start_op(op, a, b);
    wait_done(cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if ({bus.Busy, bus.Done, bus.DivByZero} !== 3'b000 || bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy/done/dbz=%b%b%b hi=%h lo=%h, expected 000 0 0",
               bus.Busy, bus.Done, bus.DivByZero, bus.HiOut, bus.LoOut);
    end
    @(negedge Clk) Reset = 1'b0;
    @(posedge Clk); #1;
    vectors++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", bus.Busy, bus.Done);
    end
  endtask

  task automatic test_multu_timing();
    int cyc, bad;
    logic [31:0] ph, pl;
    ph = bus.HiOut; pl = bus.LoOut;
    push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc = 0; bad = 0;
    while (bus.Done !== 1'b1 && cyc < 100) begin
      if (bus.Busy !== 1'b1 || bus.HiOut !== ph || bus.LoOut !== pl) bad++;
      @(posedge Clk); #1; cyc++;
    end
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("FAIL multu_latency: done after %0d edges, expected 33", cyc);
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL busy_hold_during_calc: %0d bad cycles, expected 0", bad);
    end
    vectors++;
    if (bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_in_done_cycle: busy=%b, expected 0", bus.Busy);
    end
  endtask

  task automatic test_directed();
    int cyc;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);     wait_done(cyc);
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2");
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);     wait_done(cyc);
    push_exp(32'd2, 32'd14, 1'b0, "divu_100by7");
    start_op(2'b11, 32'd100, 32'd7);           wait_done(cyc);
    push_exp(32'd1, 32'hFFFF_FFFD, 1'b0, "div_7byneg2");
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);     wait_done(cyc);
    push_exp(32'h4000_0000, 32'd0, 1'b0, "mult_minxmin");
    start_op(2'b00, 32'h8000_0000, 32'h8000_0000); wait_done(cyc);
    push_exp(32'd0, 32'h8000_0000, 1'b0, "div_overflow");
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(cyc);
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("FAIL div_latency: done after %0d edges, expected 33", cyc);
    end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    push_exp(32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "div0_pos");
    start_op(2'b10, 32'h0000_1234, 32'd0);     wait_done(cyc);
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("FAIL div0_latency: done after %0d edges, expected 33", cyc);
    end
    push_exp(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, "div0_neg");
    start_op(2'b10, 32'hFFFF_FFF0, 32'd0);     wait_done(cyc);
    push_exp(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, "divu0");
    start_op(2'b11, 32'hFFFF_FFF0, 32'd0);     wait_done(cyc);
    @(posedge Clk); #1;
    vectors++;
    if (bus.DivByZero !== 1'b0 || bus.Done !== 1'b0) begin
      miscompares++;
      $display("FAIL dbz_one_pulse: dbz=%b done=%b, expected 0 0", bus.DivByZero, bus.Done);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    push_exp(32'd0, 32'd30, 1'b0, "multu_restart_ignored");
    start_op(2'b01, 32'd5, 32'd6);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    bus.Op = 2'b00; bus.inA = 32'd100; bus.inB = 32'd100; bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    wait_done(cyc);
    vectors++;
    if (cyc + 5 !== 33) begin
      miscompares++;
      $display("FAIL restart_latency: done after %0d edges, expected 33", cyc + 5);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    start_op(2'b01, 32'd5, 32'd6);
    repeat (9) @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    vectors++;
    if (bus.Busy !== 1'b0 || bus.HiOut !== 32'd0 || bus.LoOut !== 32'd0 || bus.Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0",
               bus.Busy, bus.Done, bus.HiOut, bus.LoOut);
    end
    @(negedge Clk) Reset = 1'b0;
    run_op(2'b11, 32'd100, 32'd7, "divu_after_abort", cyc);
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("FAIL after_abort_latency: done after %0d edges, expected 33", cyc);
    end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    @(negedge Clk);
    bus.WriteHi = 1'b1; bus.WrData = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    bus.WriteHi = 1'b0;
    vectors++;
    if (bus.HiOut !== 32'hDEAD_BEEF || bus.LoOut !== 32'd14) begin
      miscompares++;
      $display("FAIL mthi: hi=%h lo=%h, expected deadbeef 0000000e", bus.HiOut, bus.LoOut);
    end
    @(negedge Clk);
    bus.WriteHi = 1'b1; bus.WriteLo = 1'b1; bus.WrData = 32'hCAFE_F00D;
    @(posedge Clk); #1;
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0;
    vectors++;
    if (bus.HiOut !== 32'hCAFE_F00D || bus.LoOut !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h, expected cafef00d cafef00d", bus.HiOut, bus.LoOut);
    end
    // Move in the same cycle as Start is dropped.
    push_exp(32'd0, 32'd6, 1'b0, "multu_with_mtlo_start");
    @(negedge Clk);
    bus.WriteLo = 1'b1; bus.WrData = 32'h1111_2222;
    bus.Op = 2'b01; bus.inA = 32'd2; bus.inB = 32'd3; bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.WriteLo = 1'b0;
    vectors++;
    if (bus.LoOut !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL mtlo_with_start: lo=%h, expected cafef00d", bus.LoOut);
    end
    wait_done(cyc);
    // MTLO during Busy is dropped.
    push_exp(32'd0, 32'd12, 1'b0, "multu_mtlo_busy");
    start_op(2'b01, 32'd3, 32'd4);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    bus.WriteLo = 1'b1; bus.WrData = 32'h1234_5678;
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if (bus.LoOut !== 32'd6) begin
      miscompares++;
      $display("FAIL mtlo_busy_hold: lo=%h, expected 00000006", bus.LoOut);
    end
    @(negedge Clk) bus.WriteLo = 1'b0;
    wait_done(cyc);
  endtask

  task automatic test_back_to_back();
    int cyc, bad;
    logic [1:0]  op;
    logic [31:0] a, b;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 3) a = 32'hFFFF_FF00;
      if (i == 7) b = 32'hFFFF_FFFF;
      run_op(op, a, b, "b2b_random", cyc);
      if (cyc !== 33) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_latency: %0d operations off 33-edge latency, expected 0", bad);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 2'b00; bus.inA = '0; bus.inB = '0;
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0; bus.WrData = '0;
    test_reset();
    test_multu_timing();
    test_directed();
    test_div_by_zero();
    test_start_ignored();
    test_reset_abort();
    test_mthi_mtlo();
    test_back_to_back();
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL pending_results: %0d results never produced, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle/multicycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over 33 clock cycles and supports MTHI/MTLO writes. HiOut and LoOut feed the write-back 32-bit 2:1 result mux, which performs the MFHI/MFLO select. Busy is consumed by the hazard/stall logic.

## Interface
- DATA_W, default 32: operand width. Only 32 is supported.
- Clk  in  1  clock, rising-edge.
- Reset  in  1  reset, asynchronous, active-high.
- Start  in  1  launch operation; sampled on the rising edge.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- inA  in  32  multiplicand or dividend (rs).
- inB  in  32  multiplier or divisor (rt).
- WriteHi  in  1  MTHI strobe.
- WriteLo  in  1  MTLO strobe.
- WrData  in  32  MTHI/MTLO data.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- DivByZero  out  1  one-cycle pulse alongside Done when a DIV/DIVU had inB == 0.
- HiOut  out  32  HI register.
- LoOut  out  32  LO register.

## Operation
- FSM states: IDLE, CALC, SIGN.
- **IDLE**
  - Start=1: latch Op and the signs of inA/inB.
  - Latch the operands as magnitudes (two's-complement absolute value for MULT/DIV; raw value for the unsigned ops).
  - Load iteration counter = 31 and go to CALC.
- **CALC**
  - Multiply: one radix-2 shift-add step per cycle, building a 64-bit unsigned product.
  - Divide: one restoring shift-subtract step per cycle, building a 32-bit quotient and remainder.
  - Counter decrements each cycle. Leave for SIGN after the step taken with counter == 0 (32 steps total).
- **SIGN**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write HI = product[63:32] or remainder, LO = product[31:0] or quotient.
  - Pulse Done, return to IDLE.
- Divide by zero: HI = original inA, LO = 32'hFFFFFFFF, DivByZero pulses with Done. Total latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- MTHI/MTLO: applied only in IDLE with Start=0. The register updates on that edge. WriteHi and WriteLo may both be asserted in the same cycle.
- Start while Busy: ignored.
- WriteHi/WriteLo while Busy, or in the same IDLE cycle as Start: dropped (Start wins).

## Timing
- Reset state: Busy=0, Done=0, DivByZero=0, HiOut=0, LoOut=0, FSM=IDLE, counter=0.
- Start sampled at edge E0.
  - Busy=1 from E0 through E33. Busy is registered and equals (state != IDLE).
  - CALC steps occur at edges E1..E32.
  - SIGN executes at E33.
  - HiOut/LoOut hold new values and Done=1 during the cycle after E33. Busy=0 in that same cycle.
- A new Start is accepted in the Done cycle, which gives back-to-back issue every 34 cycles.
- HiOut/LoOut hold their previous values throughout CALC. They are never partially updated.
- Reset mid-operation aborts immediately: HI/LO=0 and all outputs return to reset values.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: ST_IDLE, ST_CALC, ST_SIGN.
  - Constants ITER_LAST = 31 and DIV0_LO = 32'hFFFFFFFF.
- Sub-module muldiv_datapath holds the magnitude registers, 64-bit accumulator, and add/subtract step logic.
  - Controlled by load/step/fix strobes from the FSM in hilo_muldiv_unit.
- The top level owns the FSM, counter, HI/LO registers, and MTHI/MTLO logic.

## Test plan
- MULTU inA=0xFFFFFFFF, inB=0xFFFFFFFF → Done one cycle after E33; HI=0xFFFFFFFE, LO=0x00000001; Busy high E0..E33.
- MULT inA=0xFFFFFFFD (−3), inB=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV inA=0xFFFFFFF9 (−7), inB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU inA=100, inB=7 → LO=14, HI=2.
- DIV inA=0x00001234, inB=0 → HI=0x00001234, LO=0xFFFFFFFF, DivByZero=1 in the Done cycle.
- Start MULTU 5×6, re-pulse Start with different operands at E5 → ignored, result HI=0, LO=30.
  - Repeat with Reset asserted at E10 → Busy=0 and HI/LO=0 immediately; a fresh Start then completes normally.
- MTHI WrData=0xDEADBEEF in IDLE → HiOut=0xDEADBEEF next cycle.
  - MTLO 0x12345678 during Busy → dropped; LO receives only the operation result.
